main_mem_backend: RTL and testbench
===================================

Name: main_mem_backend

Overview:
- Multi-cycle main-memory model downstream of the data cache.
- Serves two request types from the cache controller:
  - block refills: a read returns one aligned cache line of BLOCK_WORDS words;
  - write-throughs: a write stores one 32-bit word.
- Fixed, parameterised access latency, so the cache's Mem_Stall path is exercised by realistic miss penalties.
- Single outstanding request, valid/ready request side, one-cycle response pulse.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; must be a power of 2.
- LATENCY, 4: clock edges from request accept to response; minimum 1.
- BLOCK_WORDS, 4: words per line returned on a read; power of 2, at most DEPTH_WORDS.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_write  in  1  1 = word write, 0 = block read.
- req_addr  in  32  byte address; bits [1:0] ignored.
- req_wdata  in  32  write data.
- req_ready  out  1  high when a request can be accepted.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32*BLOCK_WORDS  line data; word k occupies bits [32k+31:32k].
- busy  out  1  high from accept until resp_valid drops.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE;
  - resp_valid = 0, resp_rdata = 0, busy = 0;
  - req_ready = 1 once rst deasserts;
  - the memory array is not reset.
- Word index: idx = req_addr[31:2] mod DEPTH_WORDS. Out-of-range addresses wrap.
- Line base: base = idx with the low log2(BLOCK_WORDS) bits cleared.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - Accept occurs on a rising edge where req_valid && req_ready.
  - On accept, latch write, idx and wdata; load cnt = LATENCY; go to WAIT.
  - req_addr, req_write and req_wdata are sampled only on the accepting edge.
- WAIT:
  - req_ready = 0, busy = 1.
  - On each edge, cnt decrements.
  - On the edge where cnt == 1 the operation commits:
    - read: resp_rdata word k = mem[base+k];
    - write: mem[idx] = wdata, and resp_rdata keeps its previous value.
  - After the commit edge, go to RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle, then return to IDLE.
  - req_ready = 0 during RESP.
- Latency: resp_valid is high in the cycle following the LATENCY-th edge after the accepting edge.
- Throughput: minimum spacing between accepts is LATENCY+1 edges. With req_valid held high, the next accept happens on the edge that ends RESP.
- req_valid while req_ready = 0 is ignored; there is no queueing.
- resp_rdata stays stable from the commit until the next read commit.
- Reset mid-operation:
  - the pending request is dropped and no resp_valid is generated;
  - an uncommitted write leaves memory unchanged;
  - an already committed write persists.
- LATENCY = 1: commit on the first edge after accept, resp_valid in the next cycle.

Optional Feature:
- Macro: MAIN_MEM_STATS_EN.
- When defined, adds outputs stat_reads (out, 32) and stat_writes (out, 32):
  - each increments on the commit edge of its request type;
  - each saturates at 0xFFFFFFFF;
  - both reset to 0 asynchronously.
- When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Test Plan:
- Single write, defaults: release reset; write 0xDEADBEEF to 0x10, accepted at edge E → req_ready low after E; resp_valid high only in the cycle after edge E+4; busy high for 5 cycles.
- Block read after writes: write 0x11, 0x22, 0x33, 0x44 to 0x10, 0x14, 0x18, 0x1C; read 0x14 → resp_rdata = 0x00000044_00000033_00000022_00000011.
- Back-to-back: hold req_valid=1 across two reads → second accept on the edge ending RESP; two resp_valid pulses 5 cycles apart; no extra accepts while busy.
- Address wrap: write 0xCAFE0001 to byte address 4*DEPTH_WORDS+0x8 (0x1008), then read 0x0 → word 2 of resp_rdata = 0xCAFE0001.
- Reset mid-op: mem[0x20] holds 0; accept a write of 0x12345678 to 0x20; pull rst low 2 cycles later → no resp_valid, req_ready=1 after release; read 0x20 → word 0 = 0.
- Stats (MAIN_MEM_STATS_EN defined): 3 writes then 2 reads → stat_writes = 3, stat_reads = 2; assert rst → both 0.

Source files
------------

// File: rtl/main_mem_backend.sv
// Fixed-latency main memory behind the data cache: one-word write-through, aligned line refill.
// Define MAIN_MEM_STATS_EN to add saturating stat_reads / stat_writes commit counters.
module main_mem_backend #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 4,
   parameter int BLOCK_WORDS = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   input  logic                      req_write,
   input  logic [31:0]               req_addr,
   input  logic [31:0]               req_wdata,
   output logic                      req_ready,
   output logic                      resp_valid,
   output logic [32*BLOCK_WORDS-1:0] resp_rdata,
   output logic                      busy
`ifdef MAIN_MEM_STATS_EN
   ,
   output logic [31:0]               stat_reads,
   output logic [31:0]               stat_writes
`endif
);

   localparam int IDX_W  = $clog2(DEPTH_WORDS);
   localparam int CNT_W  = $clog2(LATENCY + 1);
   localparam int LINE_W = 32 * BLOCK_WORDS;
   localparam logic [IDX_W-1:0] OFF_MASK = IDX_W'(BLOCK_WORDS - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               req_ready_q;
   logic               resp_valid_q;
   logic               busy_q;
   logic [LINE_W-1:0]  resp_rdata_q;

   logic               write_q;
   logic [IDX_W-1:0]   idx_q;
   logic [31:0]        wdata_q;
   logic [31:0]        mem_q [DEPTH_WORDS];

   logic               accept;
   logic               commit;
   logic [IDX_W-1:0]   base_d;
   logic [LINE_W-1:0]  line_d;
   logic               unused_addr;

   // A request still held high while RESP ends is taken on that same edge,
   // so back-to-back requests are spaced LATENCY+1 edges apart.
   assign accept      = req_valid && (state_q == IDLE || state_q == RESP);
   assign commit      = (state_q == WAIT) && (cnt_q == CNT_W'(1));
   assign base_d      = idx_q & ~OFF_MASK;
   assign unused_addr = ^{req_addr[1:0], req_addr[31:IDX_W+2]};

   always_comb begin
      line_d = '0;
      for (int k = 0; k < BLOCK_WORDS; k++) begin
         line_d[32*k +: 32] = mem_q[base_d + IDX_W'(k)];
      end
   end

   // Request capture and array write; neither is reset, so a dropped write never reaches memory.
   always_ff @(posedge clk) begin
      if (accept) begin
         write_q <= req_write;
         idx_q   <= req_addr[IDX_W+1:2];
         wdata_q <= req_wdata;
      end
      if (commit && write_q) begin
         mem_q[idx_q] <= wdata_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         resp_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  state_q     <= WAIT;
                  cnt_q       <= CNT_W'(LATENCY);
                  req_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
               end
            end
            WAIT: begin
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_q      <= RESP;
                  resp_valid_q <= 1'b1;
                  if (!write_q) begin
                     resp_rdata_q <= line_d;
                  end
               end
            end
            RESP: begin
               if (req_valid) begin
                  state_q <= WAIT;
                  cnt_q   <= CNT_W'(LATENCY);
               end else begin
                  state_q     <= IDLE;
                  req_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state_q     <= IDLE;
               req_ready_q <= 1'b1;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign busy       = busy_q;

`ifdef MAIN_MEM_STATS_EN
   logic [31:0] stat_reads_q;
   logic [31:0] stat_writes_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_reads_q  <= '0;
         stat_writes_q <= '0;
      end else if (commit) begin
         if (write_q && stat_writes_q != 32'hFFFF_FFFF) begin
            stat_writes_q <= stat_writes_q + 32'd1;
         end
         if (!write_q && stat_reads_q != 32'hFFFF_FFFF) begin
            stat_reads_q <= stat_reads_q + 32'd1;
         end
      end
   end

   assign stat_reads  = stat_reads_q;
   assign stat_writes = stat_writes_q;
`endif

endmodule

// File: tb/tb_main_mem_backend.sv
// Bench for main_mem_backend: directed steps plus random traffic against an array model of memory.
module tb_main_mem_backend;

   localparam int DEPTH = 1024;
   localparam int LAT   = 4;
   localparam int BW    = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           req_valid = 1'b0;
   logic           req_write = 1'b0;
   logic [31:0]    req_addr  = '0;
   logic [31:0]    req_wdata = '0;
   logic           req_ready;
   logic           resp_valid;
   logic [32*BW-1:0] resp_rdata;
   logic           busy;
`ifdef MAIN_MEM_STATS_EN
   logic [31:0]    stat_reads;
   logic [31:0]    stat_writes;
`endif

   int             ntests = 0;
   int             nfail  = 0;
   logic [31:0]    mem_m [DEPTH];
   logic [127:0]   last_line_m;

   always #5 clk = ~clk;

   main_mem_backend #(
      .DEPTH_WORDS(DEPTH),
      .LATENCY    (LAT),
      .BLOCK_WORDS(BW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .busy       (busy)
`ifdef MAIN_MEM_STATS_EN
      ,
      .stat_reads (stat_reads),
      .stat_writes(stat_writes)
`endif
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int word_idx(input logic [31:0] addr);
      return int'(addr[31:2] % 30'(DEPTH));
   endfunction

   function automatic logic [127:0] exp_line(input logic [31:0] addr);
      logic [127:0] l;
      int           base;
      base = word_idx(addr) - (word_idx(addr) % BW);
      l = '0;
      for (int k = 0; k < BW; k++) l[32*k +: 32] = mem_m[base + k];
      return l;
   endfunction

   // Issue one request from IDLE; lat = edges from accept to the edge before resp_valid, -1 on timeout.
   task automatic do_op(input logic wr, input logic [31:0] addr, input logic [31:0] wd, output int lat);
      @(negedge clk);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_wdata = $urandom;
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (resp_valid) begin
            lat = n - 1;
            break;
         end
      end
   endtask

   task automatic run_op(input logic wr, input logic [31:0] addr, input logic [31:0] wd, input string tag);
      int           lat;
      logic [127:0] e;
      do_op(wr, addr, wd, lat);
      chk({tag, " latency"}, 128'(lat), 128'(LAT));
      if (wr) begin
         mem_m[word_idx(addr)] = wd;
         chk({tag, " rdata hold"}, resp_rdata, last_line_m);
      end else begin
         e = exp_line(addr);
         chk({tag, " line"}, resp_rdata, e);
         last_line_m = e;
      end
   endtask

   initial begin
      int lat, bad, busy_cnt, pulses, resp_at, p1, p2;
      logic [127:0] e1, e2;

      // Reset
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset resp_valid", 128'(resp_valid), 128'(0));
      chk("reset busy", 128'(busy), 128'(0));
      chk("reset rdata", resp_rdata, 128'(0));
      rst = 1'b1;
      @(negedge clk);
      chk("post-reset req_ready", 128'(req_ready), 128'(1));
      last_line_m = '0;

      // Bring the array to a known all-zero state
      bad = 0;
      for (int i = 0; i < DEPTH; i++) begin
         do_op(1'b1, 32'(i * 4), 32'h0, lat);
         mem_m[i] = 32'h0;
         if (lat != LAT) bad++;
      end
      chk("init latencies", 128'(bad), 128'(0));

      // Single write timing
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
      @(posedge clk);
      #1 req_valid = 1'b0;
      busy_cnt = 0; pulses = 0; resp_at = -1;
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         if (n == 1) chk("ready low after accept", 128'(req_ready), 128'(0));
         if (busy) busy_cnt++;
         if (resp_valid) begin
            pulses++;
            resp_at = n - 1;
         end
      end
      mem_m[4] = 32'hDEADBEEF;
      chk("write resp edge", 128'(resp_at), 128'(LAT));
      chk("write resp pulses", 128'(pulses), 128'(1));
      chk("write busy cycles", 128'(busy_cnt), 128'(LAT + 1));
      chk("ready back in idle", 128'(req_ready), 128'(1));

      // Block read after writes
      run_op(1'b1, 32'h10, 32'h11, "wr10");
      run_op(1'b1, 32'h14, 32'h22, "wr14");
      run_op(1'b1, 32'h18, 32'h33, "wr18");
      run_op(1'b1, 32'h1C, 32'h44, "wr1c");
      run_op(1'b0, 32'h14, 32'h0, "rd14");
      chk("rd14 literal", resp_rdata, 128'h00000044_00000033_00000022_00000011);

      // Back-to-back reads with req_valid held high
      run_op(1'b1, 32'h40, 32'hA0A0_0001, "wr40");
      run_op(1'b1, 32'h44, 32'hA0A0_0002, "wr44");
      run_op(1'b1, 32'h4C, 32'hA0A0_0004, "wr4c");
      e1 = exp_line(32'h40);
      e2 = exp_line(32'h10);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40;
      @(posedge clk);
      #1 req_addr = 32'h10;
      pulses = 0; p1 = -1; p2 = -1;
      for (int n = 1; n <= 16; n++) begin
         @(negedge clk);
         if (n == 5) chk("b2b ready in resp", 128'(req_ready), 128'(0));
         if (n == 9) req_valid = 1'b0;
         if (resp_valid) begin
            pulses++;
            if (pulses == 1) begin
               p1 = n - 1;
               chk("b2b first line", resp_rdata, e1);
            end else if (pulses == 2) begin
               p2 = n - 1;
               chk("b2b second line", resp_rdata, e2);
            end
         end
      end
      chk("b2b first edge", 128'(p1), 128'(LAT));
      chk("b2b second edge", 128'(p2), 128'(2 * LAT + 1));
      chk("b2b pulse count", 128'(pulses), 128'(2));
      last_line_m = e2;

      // Address wrap
      run_op(1'b1, 32'h1008, 32'hCAFE0001, "wrap wr");
      run_op(1'b0, 32'h0, 32'h0, "wrap rd");
      chk("wrap word2", 128'(resp_rdata[95:64]), 128'(32'hCAFE0001));

      // Reset in the middle of an uncommitted write
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst busy", 128'(busy), 128'(0));
      chk("midrst resp_valid", 128'(resp_valid), 128'(0));
      chk("midrst rdata", resp_rdata, 128'(0));
      last_line_m = '0;
      @(negedge clk);
      rst = 1'b1;
      pulses = 0;
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         if (resp_valid) pulses++;
      end
      chk("midrst no resp", 128'(pulses), 128'(0));
      chk("midrst ready", 128'(req_ready), 128'(1));
      run_op(1'b0, 32'h20, 32'h0, "midrst rd");
      chk("midrst word0", 128'(resp_rdata[31:0]), 128'(0));

      // Random traffic
      for (int i = 0; i < 60; i++) begin
         logic        wr;
         logic [31:0] a;
         wr = 1'($urandom_range(0, 1));
         a  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 255));
         run_op(wr, a, $urandom, wr ? "rand wr" : "rand rd");
      end

`ifdef MAIN_MEM_STATS_EN
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("stats reset reads", 128'(stat_reads), 128'(0));
      chk("stats reset writes", 128'(stat_writes), 128'(0));
      last_line_m = '0;
      @(negedge clk);
      rst = 1'b1;
      run_op(1'b1, 32'h100, 32'h1, "st wr0");
      run_op(1'b1, 32'h104, 32'h2, "st wr1");
      run_op(1'b1, 32'h108, 32'h3, "st wr2");
      run_op(1'b0, 32'h100, 32'h0, "st rd0");
      run_op(1'b0, 32'h200, 32'h0, "st rd1");
      chk("stat_writes", 128'(stat_writes), 128'(3));
      chk("stat_reads", 128'(stat_reads), 128'(2));
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("stat_writes cleared", 128'(stat_writes), 128'(0));
      chk("stat_reads cleared", 128'(stat_reads), 128'(0));
      @(negedge clk);
      rst = 1'b1;
`endif

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
